// File: rtl/sr_latch_driver_pkg.sv
// Purpose: shared op codes and FSM state encodings for the SR latch driver.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sr_latch_driver_pkg;

  // Request op codes
  localparam logic [1:0] OP_STROBE = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RST    = 2'b10;
  localparam logic [1:0] OP_ILL    = 2'b11;

  // Write sequencer phases
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ENABLE = 2'b10,
    ST_HOLD   = 2'b11
  } state_t;

endpackage

// File: rtl/sr_latch_driver_if.sv
// Purpose: request handshake, latch drive and status bundle for sr_latch_driver.
// Latency: n/a (wiring only).
// Backpressure: req_ready from the slave side gates req_valid.
interface sr_latch_driver_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic       S;
  logic       R;
  logic       C;
  logic       Q_fb;
  logic       done;
  logic       err_illegal;
  logic       err_verify;

  // Requester / latch side
  modport master (
    output req_valid, req_op, Q_fb,
    input  req_ready, S, R, C, done, err_illegal, err_verify
  );

  // Driver block side
  modport slave (
    input  req_valid, req_op, Q_fb,
    output req_ready, S, R, C, done, err_illegal, err_verify
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Purpose: sequences set/reset/strobe requests into setup, C pulse, hold on an SR latch, then verifies Q.
// Latency: done pulses SETUP_CYC+PULSE_CYC+HOLD_CYC edges after the accept edge.
// Backpressure: req_ready=0 while a write is in flight; requests are ignored (not queued) then.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 4
) (
  input  logic              CLK,
  input  logic              RST,
  sr_latch_driver_if.slave  bus
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [1:0]       op_q, op_n;
  logic             s_q, s_n;
  logic             r_q, r_n;
  logic             c_q, c_n;
  logic             rdy_q, rdy_n;
  logic             done_q, done_n;
  logic             ill_q, ill_n;
  logic             ver_q, ver_n;

  assign bus.S           = s_q;
  assign bus.R           = r_q;
  assign bus.C           = c_q;
  assign bus.req_ready   = rdy_q;
  assign bus.done        = done_q;
  assign bus.err_illegal = ill_q;
  assign bus.err_verify  = ver_q;

  // State and output registers; reset forces every output low except req_ready
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_STROBE;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      c_q     <= 1'b0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      ver_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      op_q    <= op_n;
      s_q     <= s_n;
      r_q     <= r_n;
      c_q     <= c_n;
      rdy_q   <= rdy_n;
      done_q  <= done_n;
      ill_q   <= ill_n;
      ver_q   <= ver_n;
    end
  end

  // Next-state and next-output logic; status pulses default low so they self-clear
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    op_n    = op_q;
    s_n     = s_q;
    r_n     = r_q;
    c_n     = c_q;
    rdy_n   = rdy_q;
    done_n  = 1'b0;
    ill_n   = 1'b0;
    ver_n   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && rdy_q) begin
          if (bus.req_op == OP_ILL) begin
            ill_n = 1'b1;
          end else begin
            // op bits map straight onto S/R, and 11 never gets here, so S=R=1 is impossible
            op_n    = bus.req_op;
            s_n     = bus.req_op[0];
            r_n     = bus.req_op[1];
            cnt_n   = SETUP_LD;
            rdy_n   = 1'b0;
            state_n = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          c_n     = 1'b1;
          cnt_n   = PULSE_LD;
          state_n = ST_ENABLE;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      ST_ENABLE: begin
        if (cnt_q == '0) begin
          c_n     = 1'b0;
          cnt_n   = HOLD_LD;
          state_n = ST_HOLD;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          s_n     = 1'b0;
          r_n     = 1'b0;
          done_n  = 1'b1;
          rdy_n   = 1'b1;
          state_n = ST_IDLE;
          // Strobe-only writes leave Q undefined from our view, so only set/reset are verified
          ver_n   = ((op_q == OP_SET) && (bus.Q_fb != 1'b1)) ||
                    ((op_q == OP_RST) && (bus.Q_fb != 1'b0));
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        op_n    = OP_STROBE;
        s_n     = 1'b0;
        r_n     = 1'b0;
        c_n     = 1'b0;
        rdy_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Purpose: directed self-checking bench for sr_latch_driver driving a behavioural SR latch.
// Latency: n/a.
// Backpressure: n/a.
module tb_sr_latch_driver;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic force_q0 = 1'b0;
  logic q_latch = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_both = 0;

  sr_latch_driver_if bus ();

  sr_latch_driver #(
    .SETUP_CYC(1),
    .PULSE_CYC(2),
    .HOLD_CYC (1),
    .CNT_W    (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Gated SR latch stage: transparent while C=1 with exactly one of S/R asserted
  always_latch begin
    if (bus.C && (bus.S ^ bus.R)) q_latch <= bus.S;
  end

  assign bus.Q_fb = force_q0 ? 1'b0 : q_latch;

  // Forbidden-combination monitor, sampled away from the active edge
  always @(negedge CLK) begin
    if (bus.S && bus.R) n_both = n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents op for one accept edge, then holds req_valid with op 11 while busy
  // (must be ignored), and walks the defaults 1/2/1 timeline to the done cycle.
  task automatic run_op(input logic [1:0] op, input logic exp_q, input logic exp_ver);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    tick();                                   // edge 0: accept
    bus.req_op = 2'b11;
    chk("acc_S", bus.S, op[0]);
    chk("acc_R", bus.R, op[1]);
    chk("acc_C", bus.C, 0);
    chk("acc_rdy", bus.req_ready, 0);
    tick();                                   // edge 1: C rises
    chk("en1_C", bus.C, 1);
    chk("en1_S", bus.S, op[0]);
    chk("en1_R", bus.R, op[1]);
    chk("busy_ill", bus.err_illegal, 0);
    tick();                                   // edge 2: C still high
    chk("en2_C", bus.C, 1);
    bus.req_valid = 1'b0;
    tick();                                   // edge 3: hold, C low, S/R kept
    chk("hold_C", bus.C, 0);
    chk("hold_S", bus.S, op[0]);
    chk("hold_R", bus.R, op[1]);
    chk("hold_done", bus.done, 0);
    tick();                                   // edge 4: done
    chk("done", bus.done, 1);
    chk("done_S", bus.S, 0);
    chk("done_R", bus.R, 0);
    chk("done_rdy", bus.req_ready, 1);
    chk("done_q", bus.Q_fb, exp_q);
    chk("done_ver", bus.err_verify, exp_ver);
    chk("done_ill", bus.err_illegal, 0);
  endtask

  initial begin
    bus.req_valid = 1'($urandom_range(0, 1));
    bus.req_op    = 2'($urandom_range(0, 3));

    // 1. reset with random request inputs
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_op    = 2'($urandom_range(0, 3));
      chk("rst_S", bus.S, 0);
      chk("rst_R", bus.R, 0);
      chk("rst_C", bus.C, 0);
      chk("rst_rdy", bus.req_ready, 1);
      chk("rst_done", bus.done, 0);
      chk("rst_ill", bus.err_illegal, 0);
      chk("rst_ver", bus.err_verify, 0);
    end
    RST = 1'b0;
    bus.req_valid = 1'b0;
    tick();

    // 2. set
    run_op(2'b01, 1'b1, 1'b0);
    tick();
    chk("set_done_clr", bus.done, 0);

    // 3. reset after set
    run_op(2'b10, 1'b0, 1'b0);
    tick();
    chk("clr_done_clr", bus.done, 0);

    // 4. illegal op in IDLE
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b11;
    tick();
    bus.req_valid = 1'b0;
    chk("ill_pulse", bus.err_illegal, 1);
    chk("ill_S", bus.S, 0);
    chk("ill_R", bus.R, 0);
    chk("ill_C", bus.C, 0);
    chk("ill_rdy", bus.req_ready, 1);
    tick();
    chk("ill_clr", bus.err_illegal, 0);
    chk("ill_nodone", bus.done, 0);

    // 5. set with Q readback stuck at 0
    force_q0 = 1'b1;
    run_op(2'b01, 1'b0, 1'b1);
    tick();
    chk("ver_done_clr", bus.done, 0);
    chk("ver_clr", bus.err_verify, 0);
    force_q0 = 1'b0;

    // 5b. strobe-only is never verified even when Q disagrees with nothing
    run_op(2'b00, q_latch, 1'b0);
    tick();

    // 6a. reset during ENABLE
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("pre_rst_C", bus.C, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_C", bus.C, 0);
    chk("mid_rst_S", bus.S, 0);
    chk("mid_rst_R", bus.R, 0);
    chk("mid_rst_rdy", bus.req_ready, 1);
    tick();

    // 6b. back-to-back: op 10 presented in the done cycle of op 01
    run_op(2'b01, 1'b1, 1'b0);
    run_op(2'b10, 1'b0, 1'b0);
    tick();
    chk("b2b_done_clr", bus.done, 0);

    chk("never_S_and_R", n_both, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
